fetch_control: RTL and testbench
================================

# fetch_control

Instruction-fetch control for the single-issue MIPS pipeline. It drives `PCNext` into the program counter register from the current `PCResult`, hazard stall, and branch/jump redirect inputs. It also owns the IF/ID pipeline register, capturing the instruction read at `PCResult`. A redirect that arrives during a stall is buffered until the stall releases, so taken branches are never lost.

## Interface
Parameters:
- RESET_VECTOR, 32'h00000000, value driven on `PCNext` while `Reset` is high; matches the PC register reset value.
- NOP_WORD, 32'h00000000, instruction word inserted as a bubble.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- PCResult  in  32  current PC from the program counter register.
- Instruction  in  32  instruction memory read data at `PCResult`, valid in the same cycle.
- Stall  in  1  hazard unit request to hold the IF stage.
- Redirect  in  1  taken branch or jump resolved downstream; single-cycle pulse.
- RedirectTarget  in  32  target address, qualified by `Redirect`.
- PCNext  out  32  next PC (combinational).
- IFID_Instruction  out  32  registered instruction to the ID stage.
- IFID_PCPlus4  out  32  registered `PCResult+4` to the ID stage.
- IFID_Valid  out  1  IF/ID holds a real instruction (0 = bubble).
- FetchCount  out  32  count of valid instructions loaded into IF/ID.

## Operation
- PCPlus4 = PCResult + 32'd4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Target alignment: bits [1:0] of RedirectTarget are forced to 0 wherever used.
- State machine has two states: RUN and HOLD.
  - RUN → HOLD when Redirect && Stall; the target is latched in PendingTarget.
  - HOLD → RUN when !Stall; the pending target is applied in that cycle.
  - HOLD + Redirect + Stall: stays in HOLD; the newer target overwrites PendingTarget.
  - HOLD + Redirect + !Stall: the new Redirect target wins, PendingTarget is discarded, and the state goes to RUN.
- PCNext priority, highest first:
  1. Reset → RESET_VECTOR.
  2. Redirect && !Stall → RedirectTarget.
  3. HOLD && !Stall → PendingTarget.
  4. Stall → PCResult.
  5. Otherwise → PCPlus4.
- IF/ID update, per rising edge, priority highest first:
  1. Reset → Instruction=NOP_WORD, PCPlus4=0, Valid=0.
  2. Redirect, with or without Stall → bubble (NOP_WORD, 0, Valid=0); the flush is unconditional because the redirect is older than the instruction in ID.
  3. HOLD && !Stall → bubble, since the fetched word is wrong-path.
  4. Stall → hold all IF/ID fields.
  5. Otherwise → load Instruction, PCPlus4, Valid=1.
- FetchCount is 0 on Reset. It increments by 1 on each edge that loads Valid=1 and wraps at 2^32.
- Reset values: IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0, state=RUN, PendingTarget=0. PCNext=RESET_VECTOR while Reset is high.

## Timing
- PCNext is purely combinational from PCResult, Stall, Redirect, RedirectTarget, state, PendingTarget and Reset; there is no added cycle. The PC register samples it on the same edge.
- IF/ID latency is 1 cycle: the instruction at PCResult in cycle N appears on IFID_* in cycle N+1.
- Redirect in cycle N without Stall: PC=target in N+1; IF/ID is a bubble in N+1 and holds the target instruction in N+2.
- Redirect during Stall: PC is held until the first cycle with !Stall, and that cycle drives the target. The bubble is inserted in the following cycle.
- Reset mid-HOLD: the pending target is dropped and the state returns to RUN.
- Redirect and Reset together: Reset wins.

## Structure
- Shared package `mips_fetch_pkg` holds the state encoding (RUN, HOLD), the NOP_WORD constant, and the default RESET_VECTOR, shared with the PC register and hazard unit.
- One natural sub-module, `if_id_register`, contains the IF/ID fields with load/hold/flush controls and synchronous Reset. `fetch_control` keeps the next-PC mux, the FSM, PendingTarget and FetchCount.

## Test plan
- Reset high 2 cycles, then low with PC at 0 and Instruction=0x20080005 → PCNext=0x4; next cycle IFID_Instruction=0x20080005, IFID_PCPlus4=0x4, Valid=1, FetchCount=1.
- PCResult=0x10, Redirect=1, RedirectTarget=0x40, Stall=0 → PCNext=0x40 and IF/ID becomes a bubble; two cycles later IFID_PCPlus4=0x44.
- Stall=1 for 3 cycles with Redirect to 0x80 in the first of them → PCNext=PCResult while stalled and IF/ID is a bubble. The first !Stall cycle gives PCNext=0x80, followed by a bubble, then the instruction from 0x80.
- During HOLD (pending 0x80), a second Redirect to 0xC0 with Stall still high → after release, PCNext=0xC0, never 0x80.
- PCResult=0xFFFFFFFC with no stall → PCNext=0x00000000; RedirectTarget=0x00000103 → PCNext=0x00000100.
- Reset asserted while in HOLD → next cycle state=RUN, IFID_Valid=0, FetchCount=0, PCNext=RESET_VECTOR while Reset is high.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared IF-stage definitions used by the fetch control, PC register and hazard unit.
// Holds the fetch state encoding, the bubble word and the default reset vector.
package mips_fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Branch targets are always word aligned
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: 1-cycle capture, flush inserts a bubble, hold (neither
// load nor flush) freezes all fields for a stalled fetch stage.
module if_id_register
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instruction_in,
  input  logic [31:0] pcplus4_in,
  output logic [31:0] instruction,
  output logic [31:0] pcplus4,
  output logic        valid
);

  always_ff @(posedge Clk) begin
    if (Reset || flush) begin
      instruction <= NOP_WORD;
      pcplus4     <= 32'd0;
      valid       <= 1'b0;
    end else if (load) begin
      instruction <= instruction_in;
      pcplus4     <= pcplus4_in;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_control.sv
// Next-PC selection (combinational) and IF/ID control; IF/ID has 1-cycle latency.
// A redirect seen under Stall is parked in pending_target and applied on stall release.
module fetch_control
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] NOP_WORD     = NOP_INSTR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] PCNext,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] FetchCount
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pending_target, pending_nxt;
  logic [31:0]  pcplus4;
  logic [31:0]  target;
  logic         release_hold;
  logic         ifid_flush;
  logic         ifid_load;

  assign pcplus4      = PCResult + 32'd4;
  assign target       = align_word(RedirectTarget);
  assign release_hold = (state == HOLD) && !Stall;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= RUN;
      pending_target <= 32'd0;
    end else begin
      state          <= state_nxt;
      pending_target <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending_target;
    if (Redirect && Stall) begin
      state_nxt   = HOLD;
      pending_nxt = target;
    end else if (Redirect || release_hold) begin
      state_nxt = RUN;
    end
  end

  always_comb begin
    if (Reset)                 PCNext = RESET_VECTOR;
    else if (Redirect && !Stall) PCNext = target;
    else if (release_hold)     PCNext = pending_target;
    else if (Stall)            PCNext = PCResult;
    else                       PCNext = pcplus4;
  end

  // A redirect flushes even while stalled: it is older than the word in ID
  assign ifid_flush = Redirect || release_hold;
  assign ifid_load  = !Stall && !ifid_flush;

  if_id_register #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .Clk            (Clk),
    .Reset          (Reset),
    .load           (ifid_load),
    .flush          (ifid_flush),
    .instruction_in (Instruction),
    .pcplus4_in     (pcplus4),
    .instruction    (IFID_Instruction),
    .pcplus4        (IFID_PCPlus4),
    .valid          (IFID_Valid)
  );

  always_ff @(posedge Clk) begin
    if (Reset)          FetchCount <= 32'd0;
    else if (ifid_load) FetchCount <= FetchCount + 32'd1;
  end

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control with a cycle-level reference model and literal spot checks.
module tb_fetch_control;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] PCResult = 32'h10;
  logic [31:0] Instruction = 32'h0;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectTarget = 32'h0;
  logic [31:0] PCNext;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic [31:0] FetchCount;

  int nvec = 0;
  int nmis = 0;

  fetch_control #(.RESET_VECTOR(RV), .NOP_WORD(NOP)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .PCResult         (PCResult),
    .Instruction      (Instruction),
    .Stall            (Stall),
    .Redirect         (Redirect),
    .RedirectTarget   (RedirectTarget),
    .PCNext           (PCNext),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PCPlus4     (IFID_PCPlus4),
    .IFID_Valid       (IFID_Valid),
    .FetchCount       (FetchCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "is a branch waiting for the stall to lift" plus IF/ID contents
  bit          m_en = 0;
  bit          m_pend_v = 0;
  logic [31:0] m_pend = 0;
  logic [31:0] m_instr = 0, m_pc4 = 0, m_cnt = 0;
  logic        m_valid = 0;

  function automatic logic [31:0] exp_pcnext();
    if (Reset) return RV;
    if (Redirect && !Stall) return {RedirectTarget[31:2], 2'b00};
    if (m_pend_v && !Stall) return m_pend;
    if (Stall) return PCResult;
    return PCResult + 32'd4;
  endfunction

  always @(posedge Clk) begin
    m_en = 1;
    if (Reset) begin
      m_instr = NOP; m_pc4 = 0; m_valid = 0; m_cnt = 0;
      m_pend_v = 0; m_pend = 0;
    end else begin
      if (Redirect || (m_pend_v && !Stall)) begin
        m_instr = NOP; m_pc4 = 0; m_valid = 0;
      end else if (!Stall) begin
        m_instr = Instruction; m_pc4 = PCResult + 32'd4; m_valid = 1; m_cnt = m_cnt + 1;
      end
      if (Redirect && Stall) begin
        m_pend_v = 1; m_pend = {RedirectTarget[31:2], 2'b00};
      end else if (!Stall) begin
        m_pend_v = 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (m_en) begin
      chk("pcnext",   PCNext, exp_pcnext());
      chk("ifid_ins", IFID_Instruction, m_instr);
      chk("ifid_pc4", IFID_PCPlus4, m_pc4);
      chk("ifid_vld", {31'd0, IFID_Valid}, {31'd0, m_valid});
      chk("fcount",   FetchCount, m_cnt);
    end
  end

  // Apply one cycle of inputs just after the rising edge; literal checks follow at +4
  task automatic step(input logic rst, input logic [31:0] pc, input logic [31:0] ins,
                      input logic stl, input logic rd, input logic [31:0] tgt);
    @(posedge Clk);
    #1;
    Reset = rst; PCResult = pc; Instruction = ins;
    Stall = stl; Redirect = rd; RedirectTarget = tgt;
    #3;
  endtask

  initial begin
    step(1, 32'h10, 0, 0, 0, 0);
    chk("lit_rst_pcnext", PCNext, 32'h0);
    step(1, 32'h10, 0, 0, 1, 32'h500);
    chk("lit_rst_vs_redirect", PCNext, 32'h0);
    chk("lit_rst_valid", {31'd0, IFID_Valid}, 32'd0);
    chk("lit_rst_count", FetchCount, 32'd0);

    step(0, 32'h0, 32'h2008_0005, 0, 0, 0);
    chk("lit_first_pcnext", PCNext, 32'h4);
    step(0, 32'h4, 32'h1111_1111, 0, 0, 0);
    chk("lit_first_ifid_ins", IFID_Instruction, 32'h2008_0005);
    chk("lit_first_ifid_pc4", IFID_PCPlus4, 32'h4);
    chk("lit_first_count", FetchCount, 32'd1);

    step(0, 32'h10, 32'hAAAA_0000, 0, 1, 32'h40);
    chk("lit_redir_pcnext", PCNext, 32'h40);
    step(0, 32'h40, 32'h4040_4040, 0, 0, 0);
    chk("lit_redir_bubble", {31'd0, IFID_Valid}, 32'd0);
    step(0, 32'h44, 32'h4444_4444, 0, 0, 0);
    chk("lit_redir_target_pc4", IFID_PCPlus4, 32'h44);

    step(0, 32'h48, 32'h4848_4848, 1, 1, 32'h80);
    chk("lit_stall_hold_pc", PCNext, 32'h48);
    step(0, 32'h48, 32'h4848_4848, 1, 0, 0);
    chk("lit_stall_bubble", {31'd0, IFID_Valid}, 32'd0);
    step(0, 32'h48, 32'h4848_4848, 1, 0, 0);
    step(0, 32'h48, 32'h4848_4848, 0, 0, 0);
    chk("lit_release_pcnext", PCNext, 32'h80);
    step(0, 32'h80, 32'h8080_8080, 0, 0, 0);
    chk("lit_release_bubble", {31'd0, IFID_Valid}, 32'd0);
    step(0, 32'h84, 32'h8484_8484, 0, 0, 0);
    chk("lit_release_ins", IFID_Instruction, 32'h8080_8080);

    step(0, 32'h88, 32'h8888_8888, 1, 1, 32'h80);
    step(0, 32'h88, 32'h8888_8888, 1, 1, 32'hC0);
    step(0, 32'h88, 32'h8888_8888, 0, 0, 0);
    chk("lit_newer_pending", PCNext, 32'hC0);
    step(0, 32'hC0, 32'hC0C0_C0C0, 0, 0, 0);

    step(0, 32'hFFFF_FFFC, 32'hFFFF_0000, 0, 0, 0);
    chk("lit_wrap", PCNext, 32'h0);
    step(0, 32'h0, 32'h0000_1234, 0, 1, 32'h103);
    chk("lit_align", PCNext, 32'h100);

    step(0, 32'h100, 32'h0100_0100, 1, 1, 32'h200);
    step(0, 32'h100, 32'h0100_0100, 0, 1, 32'h300);
    chk("lit_new_redir_wins", PCNext, 32'h300);
    step(0, 32'h300, 32'h0300_0300, 0, 0, 0);
    chk("lit_pending_discarded", PCNext, 32'h304);

    step(0, 32'h304, 32'h0304_0304, 1, 1, 32'h400);
    step(1, 32'h304, 32'h0304_0304, 1, 0, 0);
    chk("lit_rst_in_hold", PCNext, RV);
    step(0, 32'h0, 32'h2008_0005, 0, 0, 0);
    chk("lit_hold_dropped", PCNext, 32'h4);
    chk("lit_post_rst_valid", {31'd0, IFID_Valid}, 32'd0);
    chk("lit_post_rst_count", FetchCount, 32'd0);
    step(0, 32'h4, 32'h0000_0004, 0, 0, 0);
    step(0, 32'h8, 32'h0000_0008, 0, 0, 0);
    chk("lit_count_two", FetchCount, 32'd2);

    @(posedge Clk);
    @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
